wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_fifo.sv | 46 ++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register/data widths, arbiter
// state and the record buffered for long-latency results.
package wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the pipeline/long-latency units and the arbiter,
// including the decode-stage scoreboard query and the register-file write port.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic              pipe_wr;
    logic [REG_W-1:0]  pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              aux_valid;
    logic [REG_W-1:0]  aux_reg;
    logic [DATA_W-1:0] aux_data;
    logic              aux_ready;
    logic              aux_issue;
    logic [REG_W-1:0]  aux_issue_reg;
    logic [REG_W-1:0]  query_reg1;
    logic [REG_W-1:0]  query_reg2;
    logic              busy1;
    logic              busy2;
    logic              stall_req;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;

    modport slave (
        input  pipe_wr, pipe_reg, pipe_data,
        input  aux_valid, aux_reg, aux_data, aux_issue, aux_issue_reg,
        input  query_reg1, query_reg2,
        output aux_ready, busy1, busy2, stall_req,
        output WriteReg, WriteData, RegWrite
    );

    modport master (
        output pipe_wr, pipe_reg, pipe_data,
        output aux_valid, aux_reg, aux_data, aux_issue, aux_issue_reg,
        output query_reg1, query_reg2,
        input  aux_ready, busy1, busy2, stall_req,
        input  WriteReg, WriteData, RegWrite
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency results; the caller guarantees
// no push when full and no pop when empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              din,
    output wb_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: storage has no reset; count gates every read, so stale words are never used.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    assign dout  = mem[head];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win, buffered long-latency
// results fill idle slots, and a starving result forces a one-cycle pipeline stall.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic         clock,
    input logic         reset,
    wb_arbiter_if.slave bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int STRV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [STRV_W-1:0] starve_cnt;
    logic [STRV_W-1:0] starve_nxt;
    logic [31:0]       pending;
    wb_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic              sel_pipe;

    assign bus.aux_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    // Writes to r0 are architecturally void, so they are never buffered.
    assign push     = bus.aux_valid && !fifo_full && (bus.aux_reg != '0);
    assign sel_pipe = bus.pipe_wr && (bus.pipe_reg != '0);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ('{rd: bus.aux_reg, data: bus.aux_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nxt     = NORMAL;
        starve_nxt    = '0;
        pop           = 1'b0;
        bus.stall_req = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        if (!reset) begin
            case (state)
                FORCE: begin
                    // Entry is guaranteed present: FORCE is only entered while it was blocked.
                    bus.stall_req = 1'b1;
                    pop           = 1'b1;
                    bus.RegWrite  = 1'b1;
                    bus.WriteReg  = head.rd;
                    bus.WriteData = head.data;
                end
                default: begin
                    if (sel_pipe) begin
                        bus.RegWrite  = 1'b1;
                        bus.WriteReg  = bus.pipe_reg;
                        bus.WriteData = bus.pipe_data;
                        if (!fifo_empty) begin
                            if (starve_cnt == STRV_W'(STARVE_LIMIT - 1)) state_nxt = FORCE;
                            else starve_nxt = starve_cnt + 1'b1;
                        end
                    end else if (!fifo_empty) begin
                        pop           = 1'b1;
                        bus.RegWrite  = 1'b1;
                        bus.WriteReg  = head.rd;
                        bus.WriteData = head.data;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // A new reservation is applied after the clear so it wins on a same-register collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (pop) pending[head.rd] <= 1'b0;
            if (bus.aux_issue && (bus.aux_issue_reg != '0)) pending[bus.aux_issue_reg] <= 1'b1;
        end
    end

    assign bus.busy1 = pending[bus.query_reg1];
    assign bus.busy2 = pending[bus.query_reg2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the writeback rules.
module tb_wb_arbiter;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {aux_ready, stall_req, RegWrite, WriteReg, WriteData, busy1, busy2}
    logic [41:0] dut_vec;
    assign dut_vec = {bus.aux_ready, bus.stall_req, bus.RegWrite, bus.WriteReg,
                      bus.WriteData, bus.busy1, bus.busy2};
    localparam logic [41:0] IDLE_VEC = {1'b1, 41'd0};

    // Behavioural model: result queue, reservation set, length of the current starvation run.
    logic [36:0] ref_q[$];
    logic [31:0] ref_pend = '0;
    int          ref_run = 0;
    bit          ref_force = 0;
    bit          last_accepted = 0;

    function automatic logic [41:0] model_vec();
        logic        rw = 1'b0;
        logic [4:0]  wr = '0;
        logic [31:0] wd = '0;
        logic        stall = 1'b0;
        logic        b1, b2;
        if (!reset) begin
            if (ref_force) begin
                stall = 1'b1; rw = 1'b1; {wr, wd} = ref_q[0];
            end else if (bus.pipe_wr && bus.pipe_reg != 5'd0) begin
                rw = 1'b1; wr = bus.pipe_reg; wd = bus.pipe_data;
            end else if (ref_q.size() > 0) begin
                rw = 1'b1; {wr, wd} = ref_q[0];
            end
        end
        b1 = (bus.query_reg1 != 5'd0) && ref_pend[bus.query_reg1];
        b2 = (bus.query_reg2 != 5'd0) && ref_pend[bus.query_reg2];
        return {ref_q.size() < FIFO_DEPTH, stall, rw, wr, wd, b1, b2};
    endfunction

    task automatic model_tick();
        int          sz = ref_q.size();
        bit          popped, blocked;
        logic [36:0] e;
        popped  = ref_force || (!(bus.pipe_wr && bus.pipe_reg != 5'd0) && sz > 0);
        blocked = !ref_force && sz > 0 && !popped;
        last_accepted = bus.aux_valid && (sz < FIFO_DEPTH);
        if (popped) begin
            e = ref_q.pop_front();
            ref_pend[e[36:32]] = 1'b0;
        end
        if (bus.aux_issue && bus.aux_issue_reg != 5'd0) ref_pend[bus.aux_issue_reg] = 1'b1;
        if (last_accepted && bus.aux_reg != 5'd0) ref_q.push_back({bus.aux_reg, bus.aux_data});
        ref_run   = blocked ? ref_run + 1 : 0;
        ref_force = (ref_run == STARVE_LIMIT);
        if (ref_force) ref_run = 0;
    endtask

    task automatic model_reset();
        ref_q.delete();
        ref_pend = '0; ref_run = 0; ref_force = 0; last_accepted = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_tick();
        #1;
    endtask

    task automatic idle();
        bus.pipe_wr = 0; bus.pipe_reg = '0; bus.pipe_data = '0;
        bus.aux_valid = 0; bus.aux_reg = '0; bus.aux_data = '0;
        bus.aux_issue = 0; bus.aux_issue_reg = '0;
        bus.query_reg1 = '0; bus.query_reg2 = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.pipe_wr = 1; bus.pipe_reg = 5'd3; bus.pipe_data = 32'hdead_beef;
        @(negedge clock);
        total++;
        if (dut_vec !== IDLE_VEC) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, IDLE_VEC);
        end
        repeat (2) @(posedge clock);
        #1 reset = 0;
        idle();
        @(negedge clock);
        total++;
        if (dut_vec !== IDLE_VEC) begin
            bad++; $display("FAIL reset_release got=%h exp=%h", dut_vec, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_single_push();
        idle();
        bus.query_reg1 = 5'd5;
        for (int c = 0; c < 4; c++) begin
            bus.aux_issue = (c == 0); bus.aux_issue_reg = 5'd5;
            bus.aux_valid = (c == 1); bus.aux_reg = 5'd5; bus.aux_data = 32'h1234_5678;
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL single_push c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            total++;
            if (c == 2 && {bus.RegWrite, bus.WriteReg, bus.WriteData, bus.busy1} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1}) begin
                bad++; $display("FAIL single_write got we=%b reg=%0d data=%h busy=%b exp we=1 reg=5 data=12345678 busy=1",
                                bus.RegWrite, bus.WriteReg, bus.WriteData, bus.busy1);
            end else if (c == 3 && {bus.RegWrite, bus.busy1} !== 2'b00) begin
                bad++; $display("FAIL single_clear got we=%b busy=%b exp we=0 busy=0", bus.RegWrite, bus.busy1);
            end
            tick();
        end
    endtask

    task automatic test_starve();
        int stall_at = -1;
        logic [31:0] d = $urandom();
        idle();
        bus.pipe_wr = 1;
        for (int c = 0; c < STARVE_LIMIT + 4; c++) begin
            bus.pipe_reg = 5'($urandom_range(1, 31)); bus.pipe_data = $urandom();
            bus.aux_valid = (c == 0); bus.aux_reg = 5'd9; bus.aux_data = d;
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL starve c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (bus.stall_req === 1'b1 && stall_at < 0) begin
                stall_at = c;
                total++;
                if ({bus.RegWrite, bus.WriteReg, bus.WriteData} !== {1'b1, 5'd9, d}) begin
                    bad++; $display("FAIL starve_write got reg=%0d data=%h exp reg=9 data=%h", bus.WriteReg, bus.WriteData, d);
                end
            end
            tick();
        end
        total++;
        if (stall_at != STARVE_LIMIT + 1) begin
            bad++; $display("FAIL starve_cycle got=%0d exp=%0d", stall_at, STARVE_LIMIT + 1);
        end
    endtask

    task automatic test_fill();
        int accepted_at = -1;
        idle();
        bus.pipe_wr = 1;
        for (int c = 0; c < 24 && accepted_at < 0; c++) begin
            bus.pipe_reg = 5'($urandom_range(1, 31)); bus.pipe_data = $urandom();
            if (c <= 4) begin
                bus.aux_valid = 1; bus.aux_reg = 5'(10 + c); bus.aux_data = $urandom();
            end
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL fill c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (c == 4 || bus.stall_req === 1'b1) begin
                total++;
                if (bus.aux_ready !== 1'b0) begin
                    bad++; $display("FAIL fill_ready c%0d got=%b exp=0", c, bus.aux_ready);
                end
            end
            tick();
            if (c >= 4 && last_accepted) accepted_at = c;
        end
        total++;
        if (accepted_at != STARVE_LIMIT + 2) begin
            bad++; $display("FAIL fill_accept got=%0d exp=%0d", accepted_at, STARVE_LIMIT + 2);
        end
        idle();
        for (int c = 0; c < FIFO_DEPTH + 2; c++) begin
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL fill_drain c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            tick();
        end
    endtask

    task automatic test_set_wins();
        idle();
        bus.query_reg1 = 5'd7;
        for (int c = 0; c < 4; c++) begin
            bus.aux_issue = (c == 0 || c == 2); bus.aux_issue_reg = 5'd7;
            bus.aux_valid = (c == 1); bus.aux_reg = 5'd7; bus.aux_data = $urandom();
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL set_wins c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (c == 3) begin
                total++;
                if (bus.busy1 !== 1'b1) begin
                    bad++; $display("FAIL set_wins_busy got=%b exp=1", bus.busy1);
                end
            end
            tick();
        end
    endtask

    task automatic test_reg_zero();
        idle();
        bus.pipe_wr = 1; bus.pipe_reg = 5'd0; bus.pipe_data = $urandom();
        bus.aux_valid = 1; bus.aux_reg = 5'd0; bus.aux_data = $urandom();
        @(negedge clock);
        total++;
        if (bus.RegWrite !== 1'b0) begin
            bad++; $display("FAIL zero_pipe got we=%b exp=0", bus.RegWrite);
        end
        tick();
        idle();
        @(negedge clock);
        total++;
        if ({bus.RegWrite, bus.aux_ready} !== 2'b01 || dut_vec !== model_vec()) begin
            bad++; $display("FAIL zero_push got=%h exp=%h", dut_vec, model_vec());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.pipe_wr = 1;
        bus.query_reg1 = 5'd20; bus.query_reg2 = 5'd21;
        for (int c = 0; c < 3; c++) begin
            bus.pipe_reg = 5'($urandom_range(1, 31)); bus.pipe_data = $urandom();
            bus.aux_valid = 1; bus.aux_reg = 5'(20 + c); bus.aux_data = $urandom();
            bus.aux_issue = 1; bus.aux_issue_reg = 5'(20 + c);
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL reset_mid_fill c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            tick();
        end
        bus.aux_valid = 0; bus.aux_issue = 0;
        reset = 1;
        model_reset();
        #1;
        total++;
        if ({bus.aux_ready, bus.RegWrite, bus.busy1, bus.busy2} !== 4'b1000) begin
            bad++; $display("FAIL reset_mid_now got rdy=%b we=%b b1=%b b2=%b exp rdy=1 we=0 b1=0 b2=0",
                            bus.aux_ready, bus.RegWrite, bus.busy1, bus.busy2);
        end
        tick();
        tick();
        reset = 0;
        bus.pipe_wr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec() || bus.RegWrite !== 1'b0) begin
                bad++; $display("FAIL reset_mid_after c%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 500; i++) begin
            if (!bus.aux_valid || last_accepted) begin
                bus.aux_valid = ($urandom_range(0, 2) == 0);
                bus.aux_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                bus.aux_data  = $urandom();
            end
            bus.pipe_wr       = ($urandom_range(0, 9) < 7);
            bus.pipe_reg      = 5'($urandom_range(0, 7));
            bus.pipe_data     = $urandom();
            bus.aux_issue     = ($urandom_range(0, 3) == 0);
            bus.aux_issue_reg = 5'($urandom_range(0, 7));
            bus.query_reg1    = 5'($urandom_range(0, 7));
            bus.query_reg2    = 5'($urandom_range(0, 7));
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL random i%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            tick();
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_single_push();
        test_starve();
        test_fill();
        test_set_wins();
        test_reg_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
